// File: rtl/dps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dps_pkg
//  Description : Shared types and constants for the dot-product sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package dps_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dps_state_e;

  // Fixed register-to-register latency of the multiply/compress core
  localparam int CORE_LATENCY = 2;

  // Lanes per chunk presented to the core
  localparam int NUM_LANES = 8;

  // Width of one compressed partial sum produced by the core
  function automatic int core_out_w(input int a_w, input int b_w);
    return a_w + b_w + 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dps_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : dps_accumulator
//  Description : Wide wrapping accumulator for the core's two partial sums,
//                with a sticky signed-overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module dps_accumulator
  import dps_pkg::*;
#(
  parameter int ACC_SIZE = 32,
  parameter int PART_W   = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [PART_W-1:0]   part_0,
  input  logic [PART_W-1:0]   part_1,
  output logic [ACC_SIZE-1:0] acc,
  output logic                ovf
);

  // Two guard bits above the widest operand hold the exact three-term sum
  localparam int SUM_W = ((ACC_SIZE > PART_W) ? ACC_SIZE : PART_W) + 2;

  logic [SUM_W-1:0] sum_full;
  logic             sum_ovf;

  // Exact signed sum; overflow when the bits above the result sign disagree
  always_comb begin
    sum_full = {{(SUM_W-ACC_SIZE){acc[ACC_SIZE-1]}}, acc}
             + {{(SUM_W-PART_W){part_0[PART_W-1]}}, part_0}
             + {{(SUM_W-PART_W){part_1[PART_W-1]}}, part_1};
    sum_ovf  = (sum_full[SUM_W-1:ACC_SIZE-1] != '0) &&
               (sum_full[SUM_W-1:ACC_SIZE-1] != '1);
  end

  // Accumulate with wrap-around; overflow flag sticks until the next clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (enable) begin
      acc <= sum_full[ACC_SIZE-1:0];
      ovf <= ovf | sum_ovf;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dot_product_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dot_product_sequencer
//  Description : Issues 8-lane chunks to the multiply/compress core, tracks
//                its fixed latency and accumulates the returned partial sums
//                into a signed dot-product result.
//  Revision    : 1.0  initial release
// ============================================================================
module dot_product_sequencer
  import dps_pkg::*;
#(
  parameter  int IN_SIZE_0  = 4,
  parameter  int IN_SIZE_1  = 8,
  parameter  int LEN_WIDTH  = 8,
  parameter  int ACC_SIZE   = 32,
  localparam int CORE_OUT_W = core_out_w(IN_SIZE_0, IN_SIZE_1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [IN_SIZE_0-1:0]  in_0_i      [0:NUM_LANES-1],
  input  logic [IN_SIZE_1-1:0]  in_1_i      [0:NUM_LANES-1],
  output logic [IN_SIZE_0-1:0]  core_in_0_o [0:NUM_LANES-1],
  output logic [IN_SIZE_1-1:0]  core_in_1_o [0:NUM_LANES-1],
  input  logic [CORE_OUT_W-1:0] core_out_i  [0:1],
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [ACC_SIZE-1:0]   res_o,
  output logic                  ovf_o
);

  dps_state_e              state;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issue_cnt;
  logic [CORE_LATENCY-1:0] valid_pipe;
  logic                    handshake;
  logic                    job_start;

  // in_ready_o is registered and high only in RUN, so this is a RUN-only accept
  assign handshake = in_valid_i & in_ready_o;
  assign job_start = (state == IDLE) & start_i;

  // Operands reach the core only on an accepted chunk; idle cycles drive zero
  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    assign core_in_0_o[lane] = handshake ? in_0_i[lane] : '0;
    assign core_in_1_o[lane] = handshake ? in_1_i[lane] : '0;
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      len_q       <= '0;
      issue_cnt   <= '0;
      busy_o      <= 1'b0;
      in_ready_o  <= 1'b0;
      res_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            len_q     <= len_i;
            issue_cnt <= '0;
            busy_o    <= 1'b1;
            if (len_i == '0) begin
              state       <= DONE;
              res_valid_o <= 1'b1;
            end else begin
              state      <= RUN;
              in_ready_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (handshake) begin
            issue_cnt <= issue_cnt + LEN_WIDTH'(1);
            if (issue_cnt == len_q - LEN_WIDTH'(1)) begin
              state      <= DRAIN;
              in_ready_o <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Only 0s shift in here, so the pipe empties once its lower bits clear
          if (valid_pipe[CORE_LATENCY-2:0] == '0) begin
            state       <= DONE;
            res_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            res_valid_o <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          in_ready_o  <= 1'b0;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Valid pipe mirrors the core latency; reset discards in-flight chunks
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe <= {valid_pipe[CORE_LATENCY-2:0], handshake};
    end
  end

  dps_accumulator #(
    .ACC_SIZE (ACC_SIZE),
    .PART_W   (CORE_OUT_W)
  ) u_acc (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (job_start),
    .enable (valid_pipe[CORE_LATENCY-1]),
    .part_0 (core_out_i[0]),
    .part_1 (core_out_i[1]),
    .acc    (res_o),
    .ovf    (ovf_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dot_product_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_product_sequencer
//  Description : Bench for dot_product_sequencer. Two instances (32- and
//                16-bit accumulators) share stimulus; each has its own
//                2-cycle core model. A job-level model predicts outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dot_product_sequencer;

  localparam int AW = 4;
  localparam int BW = 8;
  localparam int LW = 8;
  localparam int CW = AW + BW + 8;
  localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b1;
  logic [AW-1:0] a_in [0:7] = '{default: '0};
  logic [BW-1:0] b_in [0:7] = '{default: '0};

  logic          busy_a, ready_a, rv_a, ovf_a;
  logic [31:0]   res_a;
  logic [AW-1:0] cin0_a [0:7];
  logic [BW-1:0] cin1_a [0:7];
  logic [CW-1:0] cout_a [0:1] = '{default: '0};
  logic [AW-1:0] ra_a   [0:7] = '{default: '0};
  logic [BW-1:0] rb_a   [0:7] = '{default: '0};

  logic          busy_b, ready_b, rv_b, ovf_b;
  logic [15:0]   res_b;
  logic [AW-1:0] cin0_b [0:7];
  logic [BW-1:0] cin1_b [0:7];
  logic [CW-1:0] cout_b [0:1] = '{default: '0};
  logic [AW-1:0] ra_b   [0:7] = '{default: '0};
  logic [BW-1:0] rb_b   [0:7] = '{default: '0};

  dot_product_sequencer #(.IN_SIZE_0(AW), .IN_SIZE_1(BW), .LEN_WIDTH(LW), .ACC_SIZE(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .busy_o(busy_a),
    .in_valid_i(in_valid), .in_ready_o(ready_a), .in_0_i(a_in), .in_1_i(b_in),
    .core_in_0_o(cin0_a), .core_in_1_o(cin1_a), .core_out_i(cout_a),
    .res_valid_o(rv_a), .res_ready_i(res_ready), .res_o(res_a), .ovf_o(ovf_a));

  dot_product_sequencer #(.IN_SIZE_0(AW), .IN_SIZE_1(BW), .LEN_WIDTH(LW), .ACC_SIZE(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .busy_o(busy_b),
    .in_valid_i(in_valid), .in_ready_o(ready_b), .in_0_i(a_in), .in_1_i(b_in),
    .core_in_0_o(cin0_b), .core_in_1_o(cin1_b), .core_out_i(cout_b),
    .res_valid_o(rv_b), .res_ready_i(res_ready), .res_o(res_b), .ovf_o(ovf_b));

  // ---------------- helpers ----------------
  function automatic longint part(input logic [AW-1:0] a [0:7], input logic [BW-1:0] b [0:7],
                                  input int base);
    longint s = 0;
    for (int i = base; i < base + 4; i++)
      s += longint'($signed(a[i])) * longint'($signed(b[i]));
    return s;
  endfunction

  function automatic longint wrapn(input longint v, input int n);
    longint m = v & ((longint'(1) << n) - 1);
    if (m >= (longint'(1) << (n - 1))) m -= (longint'(1) << n);
    return m;
  endfunction

  function automatic bit outr(input longint v, input int n);
    return (v >= (longint'(1) << (n - 1))) || (v < -(longint'(1) << (n - 1)));
  endfunction

  // Core models: input register then output register (2-cycle latency), no reset
  always @(posedge clk) begin
    ra_a <= cin0_a;  rb_a <= cin1_a;
    cout_a[0] <= CW'(part(ra_a, rb_a, 0));
    cout_a[1] <= CW'(part(ra_a, rb_a, 4));
    ra_b <= cin0_b;  rb_b <= cin1_b;
    cout_b[0] <= CW'(part(ra_b, rb_b, 0));
    cout_b[1] <= CW'(part(ra_b, rb_b, 4));
  end

  // ---------------- job-level model ----------------
  longint cyc = 0;
  bit     m_busy = 1'b0;
  int     m_len = 0;
  int     m_issued = 0;
  longint m_done_at = NEVER;
  longint e_res32 = 0, e_res16 = 0;
  bit     e_ovf32 = 1'b0, e_ovf16 = 1'b0;
  logic   m_ready, m_hs, m_rv;

  always_comb begin
    m_ready = m_busy && (m_issued < m_len);
    m_hs    = in_valid && m_ready;
    m_rv    = m_busy && (cyc >= m_done_at);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0; m_len <= 0; m_issued <= 0; m_done_at <= NEVER;
      e_res32 <= 0; e_res16 <= 0; e_ovf32 <= 1'b0; e_ovf16 <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1; m_len <= int'(len); m_issued <= 0;
        m_done_at <= (len == '0) ? cyc + 1 : NEVER;
        e_res32 <= 0; e_res16 <= 0; e_ovf32 <= 1'b0; e_ovf16 <= 1'b0;
      end
    end else begin
      if (m_hs) begin
        m_issued <= m_issued + 1;
        e_res32  <= wrapn(e_res32 + part(a_in, b_in, 0) + part(a_in, b_in, 4), 32);
        e_res16  <= wrapn(e_res16 + part(a_in, b_in, 0) + part(a_in, b_in, 4), 16);
        e_ovf32  <= e_ovf32 | outr(e_res32 + part(a_in, b_in, 0) + part(a_in, b_in, 4), 32);
        e_ovf16  <= e_ovf16 | outr(e_res16 + part(a_in, b_in, 0) + part(a_in, b_in, 4), 16);
        if (m_issued + 1 == m_len) m_done_at <= cyc + 3;
      end
      if (m_rv && res_ready) m_busy <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_a", longint'(busy_a), longint'(m_busy));
      check("busy_b", longint'(busy_b), longint'(m_busy));
      check("in_ready_a", longint'(ready_a), longint'(m_ready));
      check("in_ready_b", longint'(ready_b), longint'(m_ready));
      check("res_valid_a", longint'(rv_a), longint'(m_rv));
      check("res_valid_b", longint'(rv_b), longint'(m_rv));
      for (int i = 0; i < 8; i++) begin
        check("core_in_0_a", longint'(cin0_a[i]), m_hs ? longint'(a_in[i]) : 64'd0);
        check("core_in_1_a", longint'(cin1_a[i]), m_hs ? longint'(b_in[i]) : 64'd0);
        check("core_in_0_b", longint'(cin0_b[i]), m_hs ? longint'(a_in[i]) : 64'd0);
        check("core_in_1_b", longint'(cin1_b[i]), m_hs ? longint'(b_in[i]) : 64'd0);
      end
      if (m_rv || !m_busy) begin
        check("res_a", longint'($signed(res_a)), e_res32);
        check("res_b", longint'($signed(res_b)), e_res16);
        check("ovf_a", longint'(ovf_a), longint'(e_ovf32));
        check("ovf_b", longint'(ovf_b), longint'(e_ovf16));
      end
    end
  end

  // ---------------- stimulus ----------------
  longint s_cyc = 0;

  task automatic do_start(input int l);
    @(posedge clk); #1;
    start = 1'b1; len = LW'(l); s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: a=b=1; 1: a=-8,b=-128; 2: a=i,b=i-4; 3: a=3,b=5
  task automatic send(input int mode);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       begin a_in[i] = AW'(1);  b_in[i] = BW'(1);     end
        1:       begin a_in[i] = AW'(-8); b_in[i] = BW'(-128);  end
        2:       begin a_in[i] = AW'(i);  b_in[i] = BW'(i - 4); end
        default: begin a_in[i] = AW'(3);  b_in[i] = BW'(5);     end
      endcase
    end
    in_valid = 1'b1;
    while (!ready_a && n < 20) begin @(posedge clk); #1; n++; end
    if (!ready_a) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input longint lat, input longint r32,
                             input longint r16, input bit o32, input bit o16);
    int n = 0;
    while (!rv_a && n < 60) begin @(negedge clk); n++; end
    if (!rv_a) check({tag, "_timeout"}, 0, 1);
    check({tag, "_latency"}, cyc - s_cyc, lat);
    check({tag, "_res32"}, longint'($signed(res_a)), r32);
    check({tag, "_res16"}, longint'($signed(res_b)), r16);
    check({tag, "_ovf32"}, longint'(ovf_a), longint'(o32));
    check({tag, "_ovf16"}, longint'(ovf_b), longint'(o16));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", longint'(busy_a), 0);
    check("reset_res_valid", longint'(rv_b), 0);
    check("reset_res", longint'(res_a), 0);

    // single chunk of ones
    do_start(1);
    send(0);
    wait_result("single", 4, 8, 8, 1'b0, 1'b0);

    // three negative chunks, back to back
    do_start(3);
    repeat (3) send(1);
    wait_result("neg3", 6, 24576, 24576, 1'b0, 1'b0);

    // bubbles between chunks, result backpressure
    res_ready = 1'b0;
    do_start(2);
    send(2);
    repeat (3) @(posedge clk);
    #1;
    send(2);
    wait_result("bubble", 8, 56, 56, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 res_ready = 1'b1;
    @(posedge clk); #1;
    check("bubble_held_res", longint'(res_a), 56);

    // zero length
    do_start(0);
    wait_result("zero", 1, 0, 0, 1'b0, 1'b0);

    // overflow only in the 16-bit instance
    do_start(4);
    repeat (4) send(1);
    wait_result("ovf", 7, 32768, -32768, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("ovf_held_idle", longint'(ovf_b), 1);

    // reset in the middle of a run, then a clean job
    do_start(4);
    send(3);
    send(3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", longint'(busy_a), 0);
    check("midrst_ready", longint'(ready_b), 0);
    check("midrst_res", longint'(res_a), 0);
    check("midrst_ovf", longint'(ovf_b), 0);
    do_start(1);
    send(0);
    wait_result("after_rst", 4, 8, 8, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
